icache_fetch: RTL and testbench
===============================

# icache_fetch

Direct-mapped, read-only instruction cache between the core's fetch path and the slow instruction memory. It serves 32-bit instruction words to the compressed-fetch unit through the core's `mem_addr_I`/`mem_rdata_I` path. It also asserts a stall while it refills a line. The data path is transparent: the byte order of memory words is passed through unchanged, and byte swapping stays in the core.

## Interface
- `BLOCKS`, default 8: number of cache lines (power of two, ≥2). Index width `IW = log2(BLOCKS)`.
- `ADDR_W`, default 30: width of the word-address field derived from `proc_addr[31:2]`.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `proc_read`  in  1: fetch request valid.
- `proc_addr`  in  32: byte address of the fetch; bits [1:0] are ignored (word-aligned fetch).
- `proc_rdata`  out  32: fetched instruction word.
- `proc_stall`  out  1: high while the request cannot be served this cycle.
- `mem_read`  out  1: line-read request to instruction memory.
- `mem_addr`  out  28: line address (`proc_addr[31:4]` of the missing line).
- `mem_rdata`  in  128: line data; word 0 is `[31:0]`, word 3 is `[127:96]`.
- `mem_ready`  in  1: one-cycle pulse; `mem_rdata` is valid in the same cycle.

## Operation
- Address split: word offset `proc_addr[3:2]`, index `proc_addr[4+IW-1:4]`, tag `proc_addr[31:4+IW]`.
- Storage per line: one valid bit, one tag, 128 data bits.
- Hit condition: `proc_read` is high, the line is valid, and the tags match.
- States:
  - IDLE: compare against the live `proc_addr`.
    - Hit: `proc_rdata` = selected word, `proc_stall` = 0.
    - Miss: `proc_stall` = 1, latch the line address into `miss_addr`, go to FETCH.
    - `proc_read` low: `proc_stall` = 0, `proc_rdata` = 0, no state change.
  - FETCH: `mem_read` = 1, `mem_addr` = latched `miss_addr`, `proc_stall` = 1.
    - Hold until `mem_ready`.
    - On `mem_ready`: write `mem_rdata` into the line at the latched index, set the tag, set valid, go to FILL.
  - FILL: `proc_stall` = 1, `mem_read` = 0. Return to IDLE unconditionally.
    - The following IDLE cycle re-compares and hits.
- While `proc_stall` is high, `proc_rdata` = 0.
- Refill always uses the latched address. The processor must hold `proc_addr` during a stall.
- Conflict miss: overwrite the resident line. Replacement is implicit in the direct mapping.
- `mem_ready` in IDLE or FILL is ignored; no storage change.
- `mem_read` never deasserts before `mem_ready` is seen in FETCH.
- Reset:
  - All valid bits cleared, state IDLE, `miss_addr` = 0.
  - Tag and data arrays need no reset.
- Reset mid-FETCH: abandon the refill. `mem_read` is 0 from the cycle after the reset edge. A `mem_ready` arriving later is ignored.

## Timing
- Hit: zero-latency combinational read; `proc_stall` low in the same cycle.
- Miss detected in cycle T (IDLE):
  - `mem_read` high from T+1.
  - If `mem_ready` arrives in cycle R, the line is written at the end of R.
  - FILL occupies R+1; the hit is served in R+2.
  - Total miss penalty = memory latency + 2 cycles.
- Output values during reset and in the cycle after it: `proc_stall` = `proc_read` (every access misses), `mem_read` = 0, `proc_rdata` = 0, `mem_addr` = 0.
- `mem_addr` is stable for the whole FETCH interval.

## Structure
- Shared package: line width (128), words per line (4), offset width (2), and the state encoding (IDLE, FETCH, FILL, 2 bits).
- Sub-module `icache_line_array`: valid, tag, and data storage with one combinational read port and one synchronous write port.
- The FSM and hit logic live in the top module.
- Expected size: about 150–250 lines of RTL.

## Test plan
- Cold miss: after reset, read 0x0000_0000 with memory latency 3 and `mem_rdata` = {0x0000_0004, 0x0000_0003, 0x0000_0002, 0x0000_0001}.
  - Expect `mem_read` high for 3 cycles, `mem_addr` = 0, stall for 5 cycles, then `proc_rdata` = 0x0000_0001.
- Same-line hits: reads of 0x4, 0x8, and 0xE right after the refill.
  - Expect 0x2, 0x3, and 0x4, each with `proc_stall` = 0 and `mem_read` = 0.
- Conflict eviction (BLOCKS = 8): read 0x000, then 0x080 (same index 0, different tag), then 0x000.
  - Expect three misses and `mem_addr` = 0x0, 0x8, 0x0.
- Reset in FETCH: pulse `rst` two cycles into a miss, then pulse `mem_ready`.
  - Expect `mem_read` low after the reset edge, no line written, and the next read of the same address misses.
- Idle and spurious ready: `proc_read` low with random `proc_addr` and a spurious `mem_ready`.
  - Expect `proc_stall` = 0, `proc_rdata` = 0, `mem_read` = 0, and no change to the arrays (a later read misses).
- Long latency: memory latency 20 cycles.
  - Expect `mem_read` and `mem_addr` held constant for all 20 cycles, with the stall released exactly 2 cycles after `mem_ready`.

Source files
------------

// File: rtl/icache_fetch_pkg.sv
// Shared constants for the instruction cache: line geometry and FSM encoding.
package icache_fetch_pkg;

    localparam int LINE_W      = 128;
    localparam int WORD_W      = 32;
    localparam int WORDS       = 4;
    localparam int OFF_W       = 2;
    localparam int LINE_ADDR_W = 28;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    // Pick one 32-bit word out of a line; word 0 sits in the low bits.
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        logic [WORDS-1:0][WORD_W-1:0] words;
        words = line;
        return words[off];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module icache_line_array
    import icache_fetch_pkg::*;
#(
    parameter int BLOCKS = 8,
    parameter int IW     = $clog2(BLOCKS),
    parameter int TAG_W  = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [BLOCKS-1:0] valid;
    logic [TAG_W-1:0]  tags [BLOCKS];
    logic [LINE_W-1:0] data [BLOCKS];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    // Valid bits are the only storage that reset must clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with a three-state refill FSM.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int BLOCKS = 8,
    parameter int ADDR_W = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   proc_read,
    input  logic [31:0]            proc_addr,
    output logic [31:0]            proc_rdata,
    output logic                   proc_stall,
    output logic                   mem_read,
    output logic [LINE_ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready
);

    localparam int IW    = $clog2(BLOCKS);
    localparam int TAG_W = ADDR_W - OFF_W - IW;

    logic [ADDR_W-1:0]      word_addr;
    logic [OFF_W-1:0]       offset;
    logic [IW-1:0]          index;
    logic [TAG_W-1:0]       tag;
    logic                   unused_byte_bits;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [LINE_ADDR_W-1:0] miss_addr;

    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [LINE_W-1:0]      rd_data;
    logic                   hit;
    logic                   wr_en;

    assign word_addr        = proc_addr[ADDR_W+1:2];
    assign offset           = word_addr[OFF_W-1:0];
    assign index            = word_addr[OFF_W +: IW];
    assign tag              = word_addr[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^proc_addr[1:0];

    icache_line_array #(
        .BLOCKS (BLOCKS),
        .IW     (IW),
        .TAG_W  (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (miss_addr[IW-1:0]),
        .wr_tag   (miss_addr[LINE_ADDR_W-1:IW]),
        .wr_data  (mem_rdata)
    );

    assign hit = proc_read && rd_valid && (rd_tag == tag);

    // While reset is asserted the state may still be stale, so the address
    // seen by memory is forced to zero alongside mem_read.
    assign mem_addr = rst ? '0 : miss_addr;

    // Next-state and output decode; reset masks everything so a stale FETCH
    // or a stale valid line cannot leak out during the reset cycle.
    always_comb begin
        state_next = state;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        wr_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (proc_read) begin
                    if (hit) begin
                        proc_rdata = word_sel(rd_data, offset);
                    end else begin
                        proc_stall = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    wr_en      = 1'b1;
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                proc_stall = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            proc_stall = proc_read;
            proc_rdata = '0;
            mem_read   = 1'b0;
            wr_en      = 1'b0;
            state_next = ST_IDLE;
        end
    end

    // State register and miss-address latch; the latch is loaded only on the
    // IDLE cycle that detects the miss so mem_addr is stable through FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            miss_addr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && proc_read && !hit) begin
                miss_addr <= word_addr[ADDR_W-1:OFF_W];
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus random reads
// against a line-residency model of a direct-mapped cache.
module tb_icache_fetch;

    localparam int BLOCKS = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read;
    logic [31:0]  proc_addr;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Which memory line (line address) currently lives in each cache slot; -1 = empty.
    int resident [BLOCKS];
    // Backing memory image, filled lazily with random lines.
    logic [127:0] mem_img [int];

    always #5 clk = ~clk;

    icache_fetch #(.BLOCKS(BLOCKS), .ADDR_W(30)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input int la);
        if (!mem_img.exists(la)) mem_img[la] = {$urandom(), $urandom(), $urandom(), $urandom()};
        return mem_img[la];
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < BLOCKS; i++) resident[i] = -1;
    endtask

    // Advance to the next falling edge; inputs change here, outputs are checked 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    // One read transaction, acting as the memory with the given latency on a miss.
    task automatic access(input logic [31:0] addr, input int lat, input string tag);
        int           la;
        int           idx;
        logic [127:0] ln;
        logic [31:0]  w;
        la  = int'(addr[31:4]);
        idx = la % BLOCKS;
        ln  = line_of(la);
        w   = ln[32*int'(addr[3:2]) +: 32];
        step();
        proc_read = 1'b1;
        proc_addr = addr;
        mem_ready = 1'b0;
        mem_rdata = junk();
        #1;
        if (resident[idx] == la) begin
            chk({tag, " hit stall"}, proc_stall, 0);
            chk({tag, " hit rdata"}, proc_rdata, w);
            chk({tag, " hit mem_read"}, mem_read, 0);
        end else begin
            chk({tag, " miss stall"}, proc_stall, 1);
            chk({tag, " miss rdata"}, proc_rdata, 0);
            chk({tag, " miss mem_read"}, mem_read, 0);
            for (int k = 1; k <= lat; k++) begin
                step();
                mem_ready = (k == lat);
                mem_rdata = (k == lat) ? ln : junk();
                #1;
                chk({tag, " fetch mem_read"}, mem_read, 1);
                chk({tag, " fetch mem_addr"}, mem_addr, addr[31:4]);
                chk({tag, " fetch stall"}, proc_stall, 1);
                chk({tag, " fetch rdata"}, proc_rdata, 0);
            end
            step();
            mem_ready = 1'b0;
            mem_rdata = junk();
            #1;
            chk({tag, " fill stall"}, proc_stall, 1);
            chk({tag, " fill mem_read"}, mem_read, 0);
            chk({tag, " fill rdata"}, proc_rdata, 0);
            resident[idx] = la;
            step();
            #1;
            chk({tag, " served stall"}, proc_stall, 0);
            chk({tag, " served rdata"}, proc_rdata, w);
            chk({tag, " served mem_read"}, mem_read, 0);
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; proc_read = 1'b0; mem_ready = 1'b0; proc_addr = $urandom();
        #1;
        chk("rst stall idle", proc_stall, 0);
        chk("rst mem_read", mem_read, 0);
        chk("rst rdata", proc_rdata, 0);
        chk("rst mem_addr", mem_addr, 0);
        step();
        proc_read = 1'b1;
        #1;
        chk("rst stall read", proc_stall, 1);
        chk("rst rdata read", proc_rdata, 0);
        step();
        rst = 1'b0; proc_read = 1'b0;
        #1;
        chk("post-rst stall", proc_stall, 0);
        chk("post-rst mem_read", mem_read, 0);
        chk("post-rst mem_addr", mem_addr, 0);
        clear_model();
    endtask

    initial begin
        rst = 1'b1; proc_read = 1'b0; proc_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
        clear_model();
        mem_img[0] = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        do_reset();

        // Cold miss with latency 3, then same-line hits.
        access(32'h0000_0000, 3, "cold");
        access(32'h0000_0004, 1, "hit4");
        access(32'h0000_0008, 1, "hit8");
        access(32'h0000_000E, 1, "hitE");
        chk("cold word1 model", proc_rdata, 32'h0000_0004);

        // Conflict eviction in slot 0.
        do_reset();
        access(32'h0000_0000, 2, "conf0a");
        access(32'h0000_0080, 2, "conf80");
        access(32'h0000_0000, 2, "conf0b");

        // Reset two cycles into a miss, then a late mem_ready.
        step();
        proc_read = 1'b1; proc_addr = 32'h0000_0100;
        #1;
        chk("rstf miss stall", proc_stall, 1);
        step();
        #1;
        chk("rstf fetch mem_read", mem_read, 1);
        chk("rstf fetch mem_addr", mem_addr, 28'h10);
        step();
        rst = 1'b1;
        #1;
        chk("rstf rst mem_read", mem_read, 0);
        chk("rstf rst stall", proc_stall, 1);
        chk("rstf rst mem_addr", mem_addr, 0);
        step();
        rst = 1'b0; proc_read = 1'b0; mem_ready = 1'b1; mem_rdata = line_of(32'h10);
        #1;
        chk("rstf late mem_read", mem_read, 0);
        chk("rstf late stall", proc_stall, 0);
        chk("rstf late rdata", proc_rdata, 0);
        chk("rstf late mem_addr", mem_addr, 0);
        clear_model();
        access(32'h0000_0100, 2, "rstf reread");

        // Idle cycles with spurious mem_ready.
        for (int i = 0; i < 4; i++) begin
            step();
            proc_read = 1'b0; proc_addr = $urandom(); mem_ready = 1'b1; mem_rdata = junk();
            #1;
            chk("idle stall", proc_stall, 0);
            chk("idle rdata", proc_rdata, 0);
            chk("idle mem_read", mem_read, 0);
        end
        access(32'h0000_3004, 2, "idle after");
        access(32'h0000_0108, 1, "idle keep");

        // Long memory latency.
        access(32'h0000_4448, 20, "long");

        // Random reads over a small footprint so hits, misses and conflicts all occur.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 7) | $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) begin
                step();
                proc_read = 1'b0; mem_ready = $urandom_range(0, 1); proc_addr = $urandom();
                #1;
                chk("rnd idle stall", proc_stall, 0);
                chk("rnd idle rdata", proc_rdata, 0);
            end
            access(a, $urandom_range(1, 4), "rnd");
        end

        step();
        proc_read = 1'b0; mem_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
